seq_divider: RTL and testbench

Multi-cycle 32-bit integer divider: the responder end of the `validIn`/`validOut` divide handshake issued by the ALU for DIV/DIVU.
- Accepts a dividend/divisor pair and runs a radix-2 restoring division, one quotient bit per cycle.
- Returns quotient on `Lo` and remainder on `Hi`, with a one-cycle `validOut` pulse that releases the ALU stall.
- Sits beside the multiplier inside the ALU wrapper, feeding the HI/LO register write path.

---
 rtl/mdu_pkg.sv | 15 +
 rtl/div_step.sv | 28 ++
 rtl/seq_divider.sv | 128 ++++++++++++
 tb/tb_seq_divider.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared multiply/divide unit types and constants
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int MDU_WIDTH = 32;
  localparam int DIV_ITERS = MDU_WIDTH;
  localparam logic [MDU_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;

  assign rem_sh = {rem_i, quo_i[WIDTH-1]};
  // Two extra bits: the shifted remainder can exceed WIDTH bits before subtraction.
  assign trial  = {1'b0, rem_sh} - {2'b00, div_i};

  always_comb begin
    rem_o = rem_sh[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], 1'b0};
    if (trial[WIDTH+1:WIDTH] == 2'b00) begin
      rem_o    = trial[WIDTH-1:0];
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed/unsigned restoring divider, quotient on Lo, remainder on Hi
module seq_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             validIn,
  input  logic             sign,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             validOut,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] step_rem, step_quo;

  function automatic logic [WIDTH-1:0] mag(input logic s, input logic [WIDTH-1:0] x);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvsr_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (validIn) begin
          cnt_d  = '0;
          qneg_d = sign & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          rneg_d = sign & SrcA[WIDTH-1];
          if (SrcB == '0) begin
            // Divide-by-zero reuses FIX to load the fixed result one edge later.
            div0_d  = 1'b1;
            rem_d   = SrcA;
            state_d = FIX;
          end else begin
            div0_d  = 1'b0;
            rem_d   = '0;
            quo_d   = mag(sign, SrcA);
            dvsr_d  = mag(sign, SrcB);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (div0_q) begin
          lo_d = WIDTH'(DIV0_QUOT);
          hi_d = rem_q;
        end else begin
          lo_d = qneg_q ? -quo_q : quo_q;
          hi_d = rneg_q ? -rem_q : rem_q;
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign validOut = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign Hi       = hi_q;
  assign Lo       = lo_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic reference
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        validIn;
  logic        sign;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        validOut;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  seq_divider dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .validIn  (validIn),
    .sign     (sign),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .validOut (validOut),
    .Hi       (Hi),
    .Lo       (Lo),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (validOut === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the edge that follows validOut.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit hold);
    logic [31:0] eq, er;
    int lat, exp_lat;
    bit seen, busy_ok;
    model(s, a, b, eq, er);
    exp_lat = (b == 32'd0) ? 1 : 33;
    sign = s; SrcA = a; SrcB = b; validIn = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    SrcA = $urandom; SrcB = $urandom; sign = ~s;
    seen = 0; lat = 0; busy_ok = 1;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(posedge clk); #1;
      if (validOut === 1'b1) begin
        seen = 1;
        lat  = k;
      end else if (busy !== 1'b1) begin
        busy_ok = 0;
      end
    end
    if (!hold) validIn = 1'b0;
    chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_lo"}, Lo, eq);
    chk({tag, "_hi"}, Hi, er);
    @(posedge clk); #1;
    chk({tag, "_vo_one"}, {31'd0, validOut}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_lo_hold"}, Lo, eq);
  endtask

  initial begin
    int p;
    logic [31:0] ra, rb;
    logic rs;
    reset_n = 1'b0; validIn = 1'b0; sign = 1'b0; SrcA = '0; SrcB = '0;
    #1;
    chk("rst_vo", {31'd0, validOut}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, "divu_100_7", 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1'b0);
    chk("div_m7_2_lo_const", Lo, 32'hFFFF_FFFD);
    chk("div_m7_2_hi_const", Hi, 32'hFFFF_FFFF);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2", 1'b0);
    chk("div_7_m2_hi_const", Hi, 32'd1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
    chk("div_ovf_lo_const", Lo, 32'h8000_0000);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divu_ovf", 1'b0);
    chk("divu_ovf_hi_const", Hi, 32'h8000_0000);
    run_op(1'b0, 32'd5, 32'd0, "divu_5_0", 1'b0);
    run_op(1'b1, 32'hFFFF_FFF0, 32'd0, "div_m16_0", 1'b0);

    p = pulses;
    run_op(1'b1, 32'd9, 32'd4, "b2b_div", 1'b0);
    run_op(1'b0, 32'd9, 32'd4, "b2b_divu", 1'b0);
    chk("b2b_pulses", 32'(pulses - p), 32'd2);

    // validIn held high through DONE must not start anything until IDLE.
    run_op(1'b0, 32'd1234, 32'd10, "hold_a", 1'b1);
    run_op(1'b1, 32'hFFFF_F000, 32'd7, "hold_b", 1'b0);

    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(rs, ra, rb, $sformatf("rnd%0d", i), 1'b0);
    end

    run_op(1'b0, 32'd100, 32'd7, "pre_rst", 1'b0);
    sign = 1'b0; SrcA = 32'd1000; SrcB = 32'd3; validIn = 1'b1;
    @(posedge clk); #1;
    validIn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    p = pulses;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_vo", {31'd0, validOut}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_hi", Hi, 32'd0);
    chk("mid_rst_lo", Lo, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("mid_rst_no_vo", 32'(pulses - p), 32'd0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, "post_rst", 1'b0);
    chk("post_rst_lo_const", Lo, 32'h0FFF_FFFF);
    chk("post_rst_hi_const", Hi, 32'h0000_000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
